axis_prbs_check: RTL
====================

AXIS_PRBS_CHECK -- requirements
Module: axisprbscheck

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 8, number of consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter LOSS_THRESH, default 4, number of consecutive mismatches in LOCKED that force a return to HUNT.
REQ-003 SHALL have parameter LGCOUNT, default 32, width of the beat and error counters.
REQ-004 SHALL fix data width at 32 bits as a local constant, C_AXIS_DATA_WIDTH = 32.
REQ-005 SHALL have port S_AXI_ACLK, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port S_AXI_ARESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have port S_AXIS_TVALID, input, 1, stream beat valid.
REQ-008 SHALL have port S_AXIS_TREADY, output, 1, stream beat ready.
REQ-009 SHALL have port S_AXIS_TDATA, input, 32, received PRBS word.
REQ-010 SHALL have port i_clear, input, 1, zeroes both counters.
REQ-011 SHALL have port o_locked, output, 1, high in LOCKED state.
REQ-012 SHALL have port o_err, output, 1, one-cycle pulse per mismatched beat while LOCKED.
REQ-013 SHALL have port o_beat_count, output, LGCOUNT, accepted beats, saturating.
REQ-014 SHALL have port o_err_count, output, LGCOUNT, mismatched beats while LOCKED, saturating.

Function
REQ-015 SHALL use POLY = {31'h0000_2001, 1'b0} and predict(x) = {^(x & POLY), x[31:1]}, the per-beat successor of the matching generator.
REQ-016 SHALL register S_AXIS_TREADY: 0 in reset, 1 every cycle thereafter; a beat is accepted when TVALID && TREADY.
REQ-017 SHALL change state, counters and outputs only on accepted beats (except reset, i_clear, o_err deassert); all outputs registered, one cycle after the accepted beat.
REQ-018 SHALL implement two states, HUNT and LOCKED, plus a have_prev flag, a prev-word register, a match counter and a miss counter.
REQ-019 HUNT, first beat after entry with have_prev=0: store word in prev, set have_prev, no compare.
REQ-020 HUNT, have_prev=1: match when word == predict(prev) and prev[31:1] != 0; match increments match counter, else match counter clears; prev <= word in both cases.
REQ-021 HUNT SHALL enter LOCKED on the beat making match counter reach LOCK_THRESH, loading expected <= predict(word), clearing miss counter.
REQ-022 LOCKED: compare word to expected; expected <= predict(expected) regardless of outcome (free-running reference, no resync on error).
REQ-023 LOCKED mismatch: o_err=1 for one cycle, o_err_count increments, miss counter increments; match clears miss counter.
REQ-024 LOCKED SHALL return to HUNT on the beat making miss counter reach LOSS_THRESH; that beat counts as an error, prev <= word, have_prev=1, match counter 0.
REQ-025 SHALL not count errors in HUNT.
REQ-026 SHALL increment o_beat_count on every accepted beat in either state.
REQ-027 Counters SHALL saturate at all-ones, never wrap.
REQ-028 i_clear SHALL zero both counters, take precedence over a simultaneous increment, and not affect state, prev, expected or o_err.

Reset
REQ-029 Reset SHALL force: HUNT, have_prev=0, match/miss counters 0, o_locked=0, o_err=0, both counters 0, S_AXIS_TREADY=0; reset mid-lock discards lock entirely.
REQ-030 Initial values SHALL equal reset values.

Verification
REQ-031 Reset, then feed 0x8000_0000, 0x4000_0000, 0x2000_0000, ... (generator sequence from fill 0x8000_0000) -> o_locked rises one cycle after the 9th beat; o_beat_count=9, o_err_count=0.
REQ-032 Locked, corrupt one beat by flipping bit 0, then resume correct sequence -> o_err one-cycle pulse, o_err_count=1, o_locked stays 1, no further errors.
REQ-033 Locked, four consecutive corrupted beats -> o_locked falls after the 4th, o_err_count=4; correct sequence then relocks after 9 more beats.
REQ-034 Locked, TVALID low for 10 cycles mid-stream -> no counter or state change; next correct beat matches.
REQ-035 Stream of all-zero words (20 beats) -> o_locked never rises, o_err_count=0, o_beat_count=20.
REQ-036 Locked with nonzero counts, assert S_AXI_ARESET one cycle, with i_clear asserted simultaneously with an error beat in a separate run -> reset: all outputs zero and TREADY=0 during reset; clear-vs-error run: o_err_count=0, o_err=1.

Source files
------------

// File: rtl/axis_prbs_check.sv
// rtl/axis_prbs_check.sv - PRBS stream checker with hunt/lock tracking and saturating beat/error counters
module axis_prbs_check #(
   parameter int LOCK_THRESH = 8,
   parameter int LOSS_THRESH = 4,
   parameter int LGCOUNT     = 32
) (
   input  logic               S_AXI_ACLK,
   input  logic               S_AXI_ARESET,
   input  logic               S_AXIS_TVALID,
   output logic               S_AXIS_TREADY,
   input  logic [31:0]        S_AXIS_TDATA,
   input  logic               i_clear,
   output logic               o_locked,
   output logic               o_err,
   output logic [LGCOUNT-1:0] o_beat_count,
   output logic [LGCOUNT-1:0] o_err_count
);

   localparam int C_AXIS_DATA_WIDTH = 32;
   localparam logic [C_AXIS_DATA_WIDTH-1:0] POLY = {31'h0000_2001, 1'b0};
   localparam int MW = $clog2(LOCK_THRESH + 1);
   localparam int LW = $clog2(LOSS_THRESH + 1);

   typedef enum logic {S_HUNT, S_LOCKED} state_t;

   // Successor of a word in the generator sequence
   function automatic logic [C_AXIS_DATA_WIDTH-1:0] predict(input logic [C_AXIS_DATA_WIDTH-1:0] x);
      return {^(x & POLY), x[C_AXIS_DATA_WIDTH-1:1]};
   endfunction

   state_t                       state, state_nxt;
   logic                         have_prev;
   logic [C_AXIS_DATA_WIDTH-1:0] prev_word;
   logic [C_AXIS_DATA_WIDTH-1:0] expected;
   logic [MW-1:0]                match_cnt;
   logic [LW-1:0]                miss_cnt;

   logic beat;
   logic hunt_match;
   logic lock_hit;
   logic locked_miss;
   logic loss_hit;
   logic err_inc;

   assign beat        = S_AXIS_TVALID && S_AXIS_TREADY;
   // An all-zero shift field would predict itself forever, so it never counts as a match
   assign hunt_match  = have_prev && (S_AXIS_TDATA == predict(prev_word))
                        && (prev_word[C_AXIS_DATA_WIDTH-1:1] != '0);
   assign lock_hit    = hunt_match && (match_cnt == MW'(LOCK_THRESH - 1));
   assign locked_miss = (S_AXIS_TDATA != expected);
   assign loss_hit    = locked_miss && (miss_cnt == LW'(LOSS_THRESH - 1));
   assign err_inc     = beat && (state == S_LOCKED) && locked_miss;

   // State register
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET)
         state <= S_HUNT;
      else
         state <= state_nxt;
   end

   // Next-state: lock after enough consecutive predictions, drop after enough consecutive misses
   always_comb begin
      state_nxt = state;
      case (state)
         S_HUNT:   if (beat && lock_hit) state_nxt = S_LOCKED;
         S_LOCKED: if (beat && loss_hit) state_nxt = S_HUNT;
         default:  state_nxt = S_HUNT;
      endcase
   end

   // State-derived outputs
   always_comb begin
      o_locked = (state == S_LOCKED);
   end

   // Tracking datapath: previous word, free-running reference, match/miss runs, error pulse
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         have_prev     <= 1'b0;
         prev_word     <= '0;
         expected      <= '0;
         match_cnt     <= '0;
         miss_cnt      <= '0;
         o_err         <= 1'b0;
         S_AXIS_TREADY <= 1'b0;
      end else begin
         S_AXIS_TREADY <= 1'b1;
         o_err         <= 1'b0;
         if (beat) begin
            if (state == S_HUNT) begin
               prev_word <= S_AXIS_TDATA;
               have_prev <= 1'b1;
               if (have_prev) begin
                  if (lock_hit) begin
                     match_cnt <= '0;
                     miss_cnt  <= '0;
                     expected  <= predict(S_AXIS_TDATA);
                  end else if (hunt_match) begin
                     match_cnt <= match_cnt + MW'(1);
                  end else begin
                     match_cnt <= '0;
                  end
               end
            end else begin
               // Reference keeps running on errors so a single bad word costs one error
               expected <= predict(expected);
               if (locked_miss) begin
                  o_err <= 1'b1;
                  if (loss_hit) begin
                     miss_cnt  <= '0;
                     prev_word <= S_AXIS_TDATA;
                     have_prev <= 1'b1;
                     match_cnt <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + LW'(1);
                  end
               end else begin
                  miss_cnt <= '0;
               end
            end
         end
      end
   end

   // Saturating counters; clear wins over a simultaneous increment
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || i_clear) begin
         o_beat_count <= '0;
         o_err_count  <= '0;
      end else begin
         if (beat && !(&o_beat_count))
            o_beat_count <= o_beat_count + LGCOUNT'(1);
         if (err_inc && !(&o_err_count))
            o_err_count <= o_err_count + LGCOUNT'(1);
      end
   end

endmodule
